fetch_pc_unit: RTL and testbench

Instruction-fetch stage of the pipelined core, directly downstream of the next-PC select logic. It holds the PC/nPC register pair (delayed-branch semantics: PC takes nPC, nPC takes the selected next-nPC value), runs the request/ready handshake with instruction memory, and loads the IF/ID pipeline register. It supplies nPC+4 back to the next-PC selector and reports fetch stalls to the hazard unit.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_unit_if.sv | 24 ++
 rtl/fetch_pc_unit_pc_npc_reg.sv | 29 ++
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_fetch_pc_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WAIT_CNT_W = 4;
    localparam logic [XLEN-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        RST_HOLD,
        FETCH,
        WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/ready handshake between the fetch stage and imem.
interface fetch_pc_unit_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_unit_pc_npc_reg.sv
// PC/nPC register pair with delayed-branch update; the new nPC is forced word-aligned.
module pc_npc_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] RESET_NPC = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] next_npc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            misaligned
);

    assign misaligned = |next_npc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_PC;
            npc <= RESET_NPC;
        end else if (load) begin
            pc  <= npc;
            npc <= {next_npc[XLEN-1:2], 2'b00};
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC/nPC pair, imem handshake FSM, wait watchdog and IF/ID register.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] RESET_NPC = 32'h0000_0004,
    parameter int unsigned     MAX_WAIT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               le,
    input  logic               flush,
    input  logic [XLEN-1:0]    next_npc,
    fetch_pc_unit_if.master    imem,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    npc,
    output logic [XLEN-1:0]    npc_plus4,
    output logic [XLEN-1:0]    if_id_instr,
    output logic [XLEN-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               fetch_stall,
    output logic               imem_timeout,
    output logic               misalign_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    fetch_state_e          state;
    logic                  req_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_inc;
    logic                  accept;
    logic                  misaligned;

    assign accept       = req_q & imem.imem_ready & le;
    assign fetch_stall  = req_q & ~imem.imem_ready;
    assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    assign npc_plus4    = npc + 32'd4;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    pc_npc_reg #(
        .RESET_PC  (RESET_PC),
        .RESET_NPC (RESET_NPC)
    ) u_pc_npc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .next_npc   (next_npc),
        .pc         (pc),
        .npc        (npc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RST_HOLD;
            req_q        <= 1'b0;
            wait_cnt     <= '0;
            imem_timeout <= 1'b0;
            misalign_err <= 1'b0;
            if_id_instr  <= NOP_WORD;
            if_id_pc     <= '0;
            if_id_valid  <= 1'b0;
        end else begin
            case (state)
                RST_HOLD: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH, WAIT: begin
                    if (le) state <= imem.imem_ready ? FETCH : WAIT;
                end
                default: begin
                    state <= RST_HOLD;
                    req_q <= 1'b0;
                end
            endcase

            // The watchdog keeps counting while le=0 so a frozen pipeline cannot hide a dead memory.
            if (accept) begin
                wait_cnt <= '0;
            end else if (fetch_stall) begin
                wait_cnt <= wait_cnt_inc;
                if (wait_cnt_inc >= WAIT_LIMIT) imem_timeout <= 1'b1;
            end

            if (accept && misaligned) misalign_err <= 1'b1;

            // Flush wins over both hold and accept; an accepted word under flush is dropped.
            if (flush || (le && !accept)) begin
                if_id_instr <= NOP_WORD;
                if_id_pc    <= '0;
                if_id_valid <= 1'b0;
            end else if (accept) begin
                if_id_instr <= imem.imem_rdata;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    logic            clk = 1'b0;
    logic            reset, le, flush, rdy, use_seq;
    logic [31:0]     nn_force;
    logic [31:0]     next_npc;
    logic [31:0]     pc, npc, npc_plus4, if_id_instr, if_id_pc;
    logic            if_id_valid, fetch_stall, imem_timeout, misalign_err;
    int unsigned     checks = 0;
    int unsigned     errors = 0;

    fetch_pc_unit_if bus();

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = rdy ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;
    assign next_npc       = use_seq ? npc_plus4 : nn_force;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .RESET_NPC (32'h0000_0004),
        .MAX_WAIT  (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .le           (le),
        .flush        (flush),
        .next_npc     (next_npc),
        .imem         (bus.master),
        .pc           (pc),
        .npc          (npc),
        .npc_plus4    (npc_plus4),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .fetch_stall  (fetch_stall),
        .imem_timeout (imem_timeout),
        .misalign_err (misalign_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; le = 1'b1; flush = 1'b0; rdy = 1'b0;
        use_seq = 1'b1; nn_force = '0;
        step(); step();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_npc", npc, 32'h4);
        check_eq("rst_npc_plus4", npc_plus4, 32'h8);
        check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("rst_instr", if_id_instr, 32'h0);
        check_eq("rst_req", {31'b0, bus.imem_req}, 32'h0);
        check_eq("rst_stall", {31'b0, fetch_stall}, 32'h0);
        check_eq("rst_errs", {30'b0, imem_timeout, misalign_err}, 32'h0);

        rdy = 1'b1; reset = 1'b0;
        step();
        check_eq("rel_req", {31'b0, bus.imem_req}, 32'h1);
        check_eq("rel_addr", bus.imem_addr, 32'h0);
        check_eq("rel_valid", {31'b0, if_id_valid}, 32'h0);
        step();
        check_eq("seq_pc0", pc, 32'h4);
        check_eq("seq_npc0", npc, 32'h8);
        check_eq("seq_ifpc0", if_id_pc, 32'h0);
        check_eq("seq_instr0", if_id_instr, word_of(32'h0));
        check_eq("seq_valid0", {31'b0, if_id_valid}, 32'h1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check_eq("seq_pc", pc, 32'(i * 4));
            check_eq("seq_ifpc", if_id_pc, 32'((i - 1) * 4));
            check_eq("seq_valid", {31'b0, if_id_valid}, 32'h1);
        end

        // Three wait cycles at pc=0x10
        rdy = 1'b0; #1;
        check_eq("stall_comb", {31'b0, fetch_stall}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", pc, 32'h10);
            check_eq("stall_valid", {31'b0, if_id_valid}, 32'h0);
            check_eq("stall_instr", if_id_instr, 32'h0);
            check_eq("stall_flag", {31'b0, fetch_stall}, 32'h1);
        end
        rdy = 1'b1; #1;
        check_eq("stall_clear", {31'b0, fetch_stall}, 32'h0);
        step();
        check_eq("stall_done_pc", pc, 32'h14);
        check_eq("stall_done_ifpc", if_id_pc, 32'h10);
        check_eq("stall_done_instr", if_id_instr, word_of(32'h10));
        check_eq("stall_no_timeout", {31'b0, imem_timeout}, 32'h0);

        // Branch: delay slot at 0x18 still fetched, then 0x100
        use_seq = 1'b0; nn_force = 32'h100;
        step();
        check_eq("br_pc", pc, 32'h18);
        check_eq("br_npc", npc, 32'h100);
        use_seq = 1'b1;
        step();
        check_eq("br_slot_pc", pc, 32'h100);
        check_eq("br_slot_ifpc", if_id_pc, 32'h18);
        step();
        check_eq("br_tgt_pc", pc, 32'h104);
        check_eq("br_tgt_ifpc", if_id_pc, 32'h100);

        // 16 wait cycles: timeout from the 15th
        rdy = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_eq("to_flag", {31'b0, imem_timeout}, (i >= 15) ? 32'h1 : 32'h0);
            check_eq("to_pc", pc, 32'h104);
        end
        rdy = 1'b1;
        step();
        check_eq("to_resume_pc", pc, 32'h108);
        check_eq("to_resume_ifpc", if_id_pc, 32'h104);
        check_eq("to_sticky", {31'b0, imem_timeout}, 32'h1);

        // Hold then flush under hold
        le = 1'b0;
        step();
        check_eq("le_pc", pc, 32'h108);
        check_eq("le_npc", npc, 32'h10C);
        check_eq("le_valid", {31'b0, if_id_valid}, 32'h1);
        check_eq("le_req", {31'b0, bus.imem_req}, 32'h1);
        check_eq("le_addr", bus.imem_addr, 32'h108);
        flush = 1'b1;
        step();
        check_eq("le_fl_pc", pc, 32'h108);
        check_eq("le_fl_npc", npc, 32'h10C);
        check_eq("le_fl_valid", {31'b0, if_id_valid}, 32'h0);
        le = 1'b1; flush = 1'b0;
        step();
        check_eq("le_rel_pc", pc, 32'h10C);
        check_eq("le_rel_ifpc", if_id_pc, 32'h108);
        check_eq("le_rel_valid", {31'b0, if_id_valid}, 32'h1);
        flush = 1'b1;
        step();
        check_eq("fl_acc_pc", pc, 32'h110);
        check_eq("fl_acc_valid", {31'b0, if_id_valid}, 32'h0);
        check_eq("fl_acc_ifpc", if_id_pc, 32'h0);
        flush = 1'b0;

        // Misaligned redirect
        check_eq("mis_pre", {31'b0, misalign_err}, 32'h0);
        use_seq = 1'b0; nn_force = 32'h103;
        step();
        check_eq("mis_pc", pc, 32'h114);
        check_eq("mis_npc", npc, 32'h100);
        check_eq("mis_flag", {31'b0, misalign_err}, 32'h1);
        use_seq = 1'b1;

        // Reset in the middle of a wait
        rdy = 1'b0;
        step(); step();
        check_eq("wait_pc", pc, 32'h114);
        reset = 1'b1;
        step();
        check_eq("mid_rst_pc", pc, 32'h0);
        check_eq("mid_rst_npc", npc, 32'h4);
        check_eq("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
        check_eq("mid_rst_errs", {30'b0, imem_timeout, misalign_err}, 32'h0);
        check_eq("mid_rst_valid", {31'b0, if_id_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
